sorted_run_source: RTL and testbench



---
 rtl/sorted_run_source_if.sv | 36 +++
 rtl/sorted_run_source.sv | 185 ++++++++++++++++++
 tb/tb_sorted_run_source.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/sorted_run_source_if.sv
// Merger input-stream bundle: upstream write handshake plus FWFT read side.
// SORTED_RUN_SOURCE_ORDER_CHECK_EN adds the o_order_err status line.
interface sorted_run_source_if #(
    parameter int DW = 32
);
    logic [DW-1:0] i_data;
    logic          i_valid;
    logic          o_ready;
    logic          i_flush;
    logic [DW-1:0] o_fifo_data;
    logic          o_fifo_empty;
    logic          i_fifo_read;
    logic          o_zero_drop;
    logic          o_underrun;
`ifdef SORTED_RUN_SOURCE_ORDER_CHECK_EN
    logic          o_order_err;

    modport slave (
        input  i_data, i_valid, i_flush, i_fifo_read,
        output o_ready, o_fifo_data, o_fifo_empty, o_zero_drop, o_underrun, o_order_err
    );
    modport master (
        output i_data, i_valid, i_flush, i_fifo_read,
        input  o_ready, o_fifo_data, o_fifo_empty, o_zero_drop, o_underrun, o_order_err
    );
`else
    modport slave (
        input  i_data, i_valid, i_flush, i_fifo_read,
        output o_ready, o_fifo_data, o_fifo_empty, o_zero_drop, o_underrun
    );
    modport master (
        output i_data, i_valid, i_flush, i_fifo_read,
        input  o_ready, o_fifo_data, o_fifo_empty, o_zero_drop, o_underrun
    );
`endif
endinterface

// File: rtl/sorted_run_source.sv
// Buffers ascending keys and presents them as runs of RUN_LEN closed by key 0.
// Optional: SORTED_RUN_SOURCE_ORDER_CHECK_EN adds a sticky ordering-error flag.
module sorted_run_source #(
    parameter int DW      = 32,
    parameter int DEPTH   = 16,
    parameter int RUN_LEN = 8
) (
    input logic                i_clk,
    input logic                i_rst_n,
    sorted_run_source_if.slave bus
);
    localparam int              AW       = $clog2(DEPTH);
    localparam int              RCW      = (RUN_LEN > 1) ? $clog2(RUN_LEN) : 1;
    localparam logic [AW:0]     W_FULL   = (AW + 1)'(DEPTH);
    localparam logic [RCW-1:0]  RUN_LAST = RCW'(RUN_LEN - 1);

    typedef enum logic {ST_STREAM = 1'b0, ST_TERM = 1'b1} state_t;

    logic [DW-1:0]  r_mem [DEPTH];
    logic [AW:0]    r_wr_ptr;
    logic [AW:0]    r_rd_ptr;
    logic [AW:0]    r_count;
    state_t         r_state;
    logic [RCW-1:0] r_run_cnt;
    logic           r_flush_pend;
    logic           r_ready;
    logic           r_fifo_empty;
    logic [DW-1:0]  r_fifo_data;
    logic           r_zero_drop;
    logic           r_underrun;

    logic           w_xfer;
    logic           w_push;
    logic           w_pop;
    logic           w_to_term;
    logic           w_flush_clr;
    logic           w_term_nxt;
    logic [AW:0]    w_count_nxt;
    logic [AW:0]    w_rd_nxt;
    logic [DW-1:0]  w_head_nxt;

    // Handshake decode, run-closing decisions and next-cycle head value.
    always_comb begin
        w_xfer      = bus.i_valid & r_ready;
        w_push      = w_xfer & (bus.i_data != {DW{1'b0}});
        w_pop       = (r_state == ST_STREAM) & bus.i_fifo_read & (r_count != {(AW + 1){1'b0}});
        w_to_term   = 1'b0;
        w_flush_clr = 1'b0;
        if (r_state == ST_STREAM) begin
            if (w_pop) begin
                w_to_term = (r_run_cnt == RUN_LAST);
            end else if (r_flush_pend && (r_count == {(AW + 1){1'b0}})) begin
                // Flush only closes a run that already has keys in it.
                w_flush_clr = 1'b1;
                w_to_term   = (r_run_cnt != {RCW{1'b0}});
            end else begin
                w_to_term   = 1'b0;
            end
        end else begin
            w_to_term = 1'b0;
        end
        w_term_nxt  = (r_state == ST_TERM) ? ~bus.i_fifo_read : w_to_term;
        w_count_nxt = r_count + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
        w_rd_nxt    = r_rd_ptr + (AW + 1)'(w_pop);
        // A key written into the slot about to become head is not in r_mem yet.
        if (w_term_nxt || (w_count_nxt == {(AW + 1){1'b0}})) begin
            w_head_nxt = {DW{1'b0}};
        end else if (w_push && (r_wr_ptr == w_rd_nxt)) begin
            w_head_nxt = bus.i_data;
        end else begin
            w_head_nxt = r_mem[w_rd_nxt[AW-1:0]];
        end
    end

    // Key storage; contents are meaningful only between the pointers.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= bus.i_data;
        end else begin
            r_mem[r_wr_ptr[AW-1:0]] <= r_mem[r_wr_ptr[AW-1:0]];
        end
    end

    // Circular buffer pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= {(AW + 1){1'b0}};
            r_rd_ptr <= {(AW + 1){1'b0}};
            r_count  <= {(AW + 1){1'b0}};
        end else begin
            r_wr_ptr <= r_wr_ptr + (AW + 1)'(w_push);
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_count_nxt;
        end
    end

    // Run FSM with its registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_STREAM;
            r_run_cnt    <= {RCW{1'b0}};
            r_flush_pend <= 1'b0;
            r_ready      <= 1'b1;
            r_fifo_empty <= 1'b1;
            r_fifo_data  <= {DW{1'b0}};
            r_zero_drop  <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_ready      <= (w_count_nxt != W_FULL);
            r_fifo_empty <= ~w_term_nxt & (w_count_nxt == {(AW + 1){1'b0}});
            r_fifo_data  <= w_head_nxt;
            r_zero_drop  <= w_xfer & (bus.i_data == {DW{1'b0}});
            r_underrun   <= r_underrun | (bus.i_fifo_read & r_fifo_empty);
            r_flush_pend <= (r_flush_pend & ~w_flush_clr) | bus.i_flush;
            case (r_state)
                ST_STREAM: begin
                    if (w_to_term) begin
                        r_state   <= ST_TERM;
                        r_run_cnt <= {RCW{1'b0}};
                    end else if (w_pop) begin
                        r_state   <= ST_STREAM;
                        r_run_cnt <= r_run_cnt + RCW'(1);
                    end else begin
                        r_state   <= ST_STREAM;
                        r_run_cnt <= r_run_cnt;
                    end
                end
                ST_TERM: begin
                    if (bus.i_fifo_read) begin
                        r_state   <= ST_STREAM;
                        r_run_cnt <= {RCW{1'b0}};
                    end else begin
                        r_state   <= ST_TERM;
                        r_run_cnt <= r_run_cnt;
                    end
                end
                default: begin
                    r_state   <= ST_STREAM;
                    r_run_cnt <= {RCW{1'b0}};
                end
            endcase
        end
    end

    assign bus.o_ready      = r_ready;
    assign bus.o_fifo_empty = r_fifo_empty;
    assign bus.o_fifo_data  = r_fifo_data;
    assign bus.o_zero_drop  = r_zero_drop;
    assign bus.o_underrun   = r_underrun;

`ifdef SORTED_RUN_SOURCE_ORDER_CHECK_EN
    logic [RCW-1:0] r_wrun_cnt;
    logic [DW-1:0]  r_last_key;
    logic           r_order_err;

    // Write-side run tracking; a flush makes the next stored key start a run.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wrun_cnt  <= {RCW{1'b0}};
            r_last_key  <= {DW{1'b0}};
            r_order_err <= 1'b0;
        end else begin
            if (bus.i_flush) begin
                r_wrun_cnt <= {RCW{1'b0}};
            end else if (w_push) begin
                r_wrun_cnt <= (r_wrun_cnt == RUN_LAST) ? {RCW{1'b0}} : r_wrun_cnt + RCW'(1);
            end else begin
                r_wrun_cnt <= r_wrun_cnt;
            end
            if (w_push) begin
                r_last_key <= bus.i_data;
            end else begin
                r_last_key <= r_last_key;
            end
            if (w_push && (r_wrun_cnt != {RCW{1'b0}}) && (bus.i_data < r_last_key)) begin
                r_order_err <= 1'b1;
            end else begin
                r_order_err <= r_order_err;
            end
        end
    end

    assign bus.o_order_err = r_order_err;
`endif
endmodule

// File: tb/tb_sorted_run_source.sv
// Directed and randomized bench for sorted_run_source against a queue-based run model.
module tb_sorted_run_source;
    localparam int DW      = 32;
    localparam int DEPTH   = 8;
    localparam int RUN_LEN = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   zd_cnt   = 0;

    sorted_run_source_if #(.DW(DW)) bif ();

    sorted_run_source #(.DW(DW), .DEPTH(DEPTH), .RUN_LEN(RUN_LEN)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bif.slave)
    );

    always #5 clk = ~clk;

    // Reference model: queue of stored keys plus run bookkeeping.
    int unsigned m_q[$];
    bit          m_term;
    int          m_run;
    bit          m_fp;
    bit          m_under;
    bit          m_zd;
    logic [DW-1:0] popped[$];

    function automatic bit exp_empty();
        return !m_term && (m_q.size() == 0);
    endfunction

    function automatic logic [DW-1:0] exp_data();
        if (m_term || m_q.size() == 0) return 32'd0;
        return m_q[0];
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_term  = 1'b0;
        m_run   = 0;
        m_fp    = 1'b0;
        m_under = 1'b0;
        m_zd    = 1'b0;
    endtask

    task automatic model_edge(input bit v, input logic [DW-1:0] d, input bit r, input bit f);
        bit was_empty = (m_q.size() == 0);
        bit e_empty   = exp_empty();
        bit xfer      = v && (m_q.size() != DEPTH);
        bit clr       = 1'b0;
        if (m_term) begin
            if (r) begin
                m_term = 1'b0;
                m_run  = 0;
            end
        end else if (r && !was_empty) begin
            void'(m_q.pop_front());
            m_run++;
            if (m_run == RUN_LEN) begin
                m_term = 1'b1;
                m_run  = 0;
            end
        end else if (m_fp && was_empty) begin
            clr = 1'b1;
            if (m_run > 0) m_term = 1'b1;
        end
        m_fp    = (m_fp && !clr) || f;
        m_under = m_under || (r && e_empty);
        m_zd    = xfer && (d == 32'd0);
        if (xfer && d != 32'd0) m_q.push_back(d);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("fifo_data",  64'(bif.o_fifo_data),  64'(exp_data()));
        check("fifo_empty", 64'(bif.o_fifo_empty), 64'(exp_empty()));
        check("ready",      64'(bif.o_ready),      64'(m_q.size() != DEPTH));
        check("zero_drop",  64'(bif.o_zero_drop),  64'(m_zd));
        check("underrun",   64'(bif.o_underrun),   64'(m_under));
    endtask

    task automatic step(input bit v, input logic [DW-1:0] d, input bit r, input bit f);
        @(negedge clk);
        bif.i_valid     = v;
        bif.i_data      = d;
        bif.i_fifo_read = r;
        bif.i_flush     = f;
        if (r && !bif.o_fifo_empty) popped.push_back(bif.o_fifo_data);
        @(posedge clk);
        model_edge(v, d, r, f);
        #1;
        check_outputs();
        if (bif.o_zero_drop) zd_cnt++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n           = 1'b0;
        bif.i_valid     = 1'b0;
        bif.i_data      = 32'd0;
        bif.i_fifo_read = 1'b0;
        bif.i_flush     = 1'b0;
        #1;
        check("rst_empty",     64'(bif.o_fifo_empty), 64'd1);
        check("rst_data",      64'(bif.o_fifo_data),  64'd0);
        check("rst_ready",     64'(bif.o_ready),      64'd1);
        check("rst_zero_drop", 64'(bif.o_zero_drop),  64'd0);
        check("rst_underrun",  64'(bif.o_underrun),   64'd0);
`ifdef SORTED_RUN_SOURCE_ORDER_CHECK_EN
        check("rst_order_err", 64'(bif.o_order_err),  64'd0);
`endif
        model_reset();
        popped.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_seq(input string tag, input int unsigned exp_q[$]);
        check({tag, "_len"}, 64'(popped.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            check(tag, (i < popped.size()) ? 64'(popped[i]) : 64'hFFFF_FFFF_FFFF_FFFF, 64'(exp_q[i]));
        end
    endtask

    initial begin
        int unsigned   exp_q[$];
        bit            v;
        bit            r;
        bit            f;
        logic [DW-1:0] d;

        bif.i_valid     = 1'b0;
        bif.i_data      = 32'd0;
        bif.i_fifo_read = 1'b0;
        bif.i_flush     = 1'b0;
        model_reset();

        // Run closure after RUN_LEN keys with reads held high.
        do_reset();
        step(1'b1, 32'd3, 1'b1, 1'b0);
        step(1'b1, 32'd5, 1'b1, 1'b0);
        step(1'b1, 32'd7, 1'b1, 1'b0);
        step(1'b1, 32'd9, 1'b1, 1'b0);
        step(1'b1, 32'd11, 1'b1, 1'b0);
        repeat (4) step(1'b0, 32'd0, 1'b1, 1'b0);
        exp_q = '{3, 5, 7, 9, 0, 11};
        check_seq("seq_run", exp_q);
        check("empty_after_11", 64'(bif.o_fifo_empty), 64'd1);

        // Full buffer back-pressure.
        do_reset();
        for (int i = 1; i <= DEPTH; i++) step(1'b1, DW'(i), 1'b0, 1'b0);
        check("ready_full", 64'(bif.o_ready), 64'd0);
        step(1'b1, 32'd100, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b1, 1'b0);
        check("ready_after_pop", 64'(bif.o_ready), 64'd1);
        repeat (12) step(1'b0, 32'd0, 1'b1, 1'b0);
        exp_q = '{1, 2, 3, 4, 0, 5, 6, 7, 8, 0};
        check_seq("seq_full", exp_q);

        // Flush closes a partial run; a flush with nothing in the run adds nothing.
        do_reset();
        step(1'b1, 32'd4, 1'b0, 1'b0);
        step(1'b1, 32'd6, 1'b0, 1'b0);
        step(1'b0, 32'd0, 1'b0, 1'b1);
        repeat (6) step(1'b0, 32'd0, 1'b1, 1'b0);
        exp_q = '{4, 6, 0};
        check_seq("seq_flush", exp_q);
        popped.delete();
        step(1'b0, 32'd0, 1'b0, 1'b1);
        repeat (4) step(1'b0, 32'd0, 1'b1, 1'b0);
        check("no_empty_run", 64'(popped.size()), 64'd0);

        // Zero keys are dropped.
        do_reset();
        zd_cnt = 0;
        step(1'b1, 32'd0, 1'b0, 1'b0);
        step(1'b1, 32'd2, 1'b0, 1'b0);
        repeat (3) step(1'b0, 32'd0, 1'b1, 1'b0);
        check("zero_drop_pulses", 64'(zd_cnt), 64'd1);
        exp_q = '{2};
        check_seq("seq_zero", exp_q);

        // Sticky underrun, then asynchronous reset mid-run.
        do_reset();
        repeat (3) step(1'b0, 32'd0, 1'b1, 1'b0);
        check("underrun_set", 64'(bif.o_underrun), 64'd1);
        repeat (2) step(1'b0, 32'd0, 1'b0, 1'b0);
        check("underrun_sticky", 64'(bif.o_underrun), 64'd1);
        step(1'b1, 32'd10, 1'b0, 1'b0);
        step(1'b1, 32'd20, 1'b1, 1'b0);
        step(1'b1, 32'd30, 1'b0, 1'b0);
        do_reset();

`ifdef SORTED_RUN_SOURCE_ORDER_CHECK_EN
        step(1'b1, 32'd5, 1'b0, 1'b0);
        step(1'b1, 32'd3, 1'b0, 1'b0);
        check("order_err_set", 64'(bif.o_order_err), 64'd1);
        do_reset();
        step(1'b1, 32'd2, 1'b0, 1'b0);
        step(1'b1, 32'd4, 1'b0, 1'b0);
        step(1'b1, 32'd6, 1'b0, 1'b0);
        step(1'b1, 32'd9, 1'b0, 1'b0);
        step(1'b1, 32'd1, 1'b0, 1'b0);
        check("order_err_new_run", 64'(bif.o_order_err), 64'd0);
        do_reset();
`endif

        // Randomized traffic: first read-starved, then read-heavy.
        for (int i = 0; i < 500; i++) begin
            v = 1'($urandom_range(0, 1));
            d = ($urandom_range(0, 9) == 0) ? 32'd0 : DW'($urandom_range(1, 1000));
            r = (i < 250) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 15) == 0);
            step(v, d, r, f);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
